simd_result_writeback: RTL
==========================

// Module: simd_result_writeback
// PURPOSE
//  Return path from the SIMD core to the memory controller (MC). The MC side pushes
//  128-bit operand pairs into simd_top_level; this block collects the per-lane results
//  (out_procc0..3, out_extra_procc0..3) and buffers them in a FIFO. It then writes them
//  back to the MC as tagged 256-bit records over a valid/ready handshake.
//  Sits between simd_top_level outputs and the MC write port, on the core clock clk.
// PARAMETERS
//  FIFO_DEPTH  4   result records buffered; power of 2, >=2
//  LANE_W      32  width of each lane result
// PORTS
//  clk              in   1    core clock, all logic on posedge
//  reset            in   1    synchronous, active-high
//  start            in   1    begin a job; sampled only in IDLE
//  instruction      in   3    opcode tag of the job, latched on start
//  data_size        in   6    number of result records expected, latched on start
//  res_valid        in   1    SIMD lanes present a valid result this cycle
//  out_procc0..3    in   32   lane primary results (4 ports)
//  out_extra_procc0..3 in 32  lane extra results (hi word/remainder, 4 ports)
//  res_ready        out  1    block accepts a result this cycle
//  mc_wr_valid      out  1    write record valid
//  mc_wr_ready      in   1    MC accepts record
//  mc_wr_data_lo    out  128  {out_procc3,out_procc2,out_procc1,out_procc0}
//  mc_wr_data_hi    out  128  {out_extra_procc3,..,out_extra_procc0}
//  mc_wr_instr      out  3    latched job opcode
//  mc_wr_index      out  6    record index within job, 0-based
//  busy             out  1    state != IDLE
//  done             out  1    one-cycle pulse at job completion
//  overrun          out  1    sticky: a result was dropped
// BEHAVIOUR
//  Reset (sync, high): state=IDLE, FIFO empty, counters 0. All outputs 0, including
//   data/instr/index.
//  Reset mid-job aborts at the next edge: FIFO is flushed, no done pulse.
//  FSM: IDLE -> COLLECT on start (data_size!=0); IDLE -> DONE on start with data_size==0.
//   COLLECT -> DRAIN when accepted count == data_size. DRAIN -> DONE when FIFO empty
//   and no record pending. DONE -> IDLE unconditionally (done=1 only in DONE).
//  Accept: res_ready = (state==COLLECT) & ~fifo_full. A push occurs on res_valid &
//   res_ready. Lanes are packed as in PORTS and tagged with index = accepted count.
//  Full FIFO: res_ready is 0 even if a pop occurs that same cycle; no bypass.
//  Drop: res_valid & ~res_ready in COLLECT sets overrun. The result is lost and
//   not counted. overrun clears on the next accepted start or on reset.
//  res_valid in IDLE/DRAIN/DONE is ignored and does not set overrun.
//  Output: mc_wr_valid = FIFO non-empty. Head record is registered. Earliest
//   mc_wr_valid is the cycle after the push. Record and valid stay stable until
//   mc_wr_valid & mc_wr_ready. Pop happens on that edge; next record is visible the
//   following cycle if present.
//  Simultaneous push and pop on a non-full FIFO: both happen; occupancy is unchanged.
//  Counters: accept count and index are 6-bit; data_size max 63, so no wrap within a job.
//   Pointers wrap modulo FIFO_DEPTH.
//  start while busy is ignored.
//  Throughput: 1 record/clk when mc_wr_ready is held high.
// TESTING
//  1 reset; start, instr=3'b000, size=3; 3 results, ready=1 -> 3 records idx 0,1,2,
//    lo=procc packing, done pulses once, busy drops.
//  2 size=6, mc_wr_ready=0, res_valid every cycle -> 4 accepted, res_ready=0,
//    overrun=1; release ready -> idx 0..3 drain in order, 2 more accepted.
//  3 ready toggles 1/0 every cycle -> no record duplicated or skipped; data stable
//    while valid & ~ready.
//  4 start with size=0 -> done on the 2nd clk, no mc_wr_valid; start while busy
//    -> ignored, instr tag unchanged.
//  5 reset asserted with 2 records queued -> next cycle mc_wr_valid=0, busy=0,
//    no done; a new job runs cleanly.
//  6 lanes=32'hffffffff and extra=32'h00000001 -> mc_wr_data_hi=
//    128'h00000001_00000001_00000001_00000001.

Source files
------------

// File: rtl/simd_result_writeback.sv
// Collects per-lane SIMD results into a small FIFO and writes them back to the
// memory controller as tagged 256-bit records over a valid/ready handshake.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | waiting for start; job parameters latched on start
// S_COLLECT | accepting lane results until data_size records are counted
// S_DRAIN   | all results accepted; emptying the FIFO toward the MC
// S_DONE    | one-cycle completion, done asserted
module simd_result_writeback #(
   parameter int FIFO_DEPTH = 4,
   parameter int LANE_W     = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [2:0]            instruction,
   input  logic [5:0]            data_size,
   input  logic                  res_valid,
   input  logic [LANE_W-1:0]     out_procc0,
   input  logic [LANE_W-1:0]     out_procc1,
   input  logic [LANE_W-1:0]     out_procc2,
   input  logic [LANE_W-1:0]     out_procc3,
   input  logic [LANE_W-1:0]     out_extra_procc0,
   input  logic [LANE_W-1:0]     out_extra_procc1,
   input  logic [LANE_W-1:0]     out_extra_procc2,
   input  logic [LANE_W-1:0]     out_extra_procc3,
   output logic                  res_ready,
   output logic                  mc_wr_valid,
   input  logic                  mc_wr_ready,
   output logic [4*LANE_W-1:0]   mc_wr_data_lo,
   output logic [4*LANE_W-1:0]   mc_wr_data_hi,
   output logic [2:0]            mc_wr_instr,
   output logic [5:0]            mc_wr_index,
   output logic                  busy,
   output logic                  done,
   output logic                  overrun
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int DW = 4 * LANE_W;

   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [2:0]        instr_q, instr_d;
   logic [5:0]        size_q, size_d;
   logic [5:0]        acc_q, acc_d;
   logic              ovr_q, ovr_d;
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic [DW-1:0]     lo_q  [FIFO_DEPTH];
   logic [DW-1:0]     lo_d  [FIFO_DEPTH];
   logic [DW-1:0]     hi_q  [FIFO_DEPTH];
   logic [DW-1:0]     hi_d  [FIFO_DEPTH];
   logic [5:0]        idx_q [FIFO_DEPTH];
   logic [5:0]        idx_d [FIFO_DEPTH];

   logic fifo_full, fifo_empty, push, pop;

   always_comb begin
      fifo_full  = (count_q == CW'(FIFO_DEPTH));
      fifo_empty = (count_q == '0);
      res_ready  = (state_q == S_COLLECT) && !fifo_full;
      push       = res_valid && res_ready;
      pop        = !fifo_empty && mc_wr_ready;

      state_d  = state_q;
      instr_d  = instr_q;
      size_d   = size_q;
      acc_d    = acc_q;
      ovr_d    = ovr_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      lo_d     = lo_q;
      hi_d     = hi_q;
      idx_d    = idx_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               instr_d = instruction;
               size_d  = data_size;
               acc_d   = '0;
               ovr_d   = 1'b0;
               state_d = (data_size == '0) ? S_DONE : S_COLLECT;
            end
         end
         S_COLLECT: begin
            if (push) acc_d = acc_q + 6'd1;
            if (res_valid && !res_ready) ovr_d = 1'b1;
            // Leave on the edge that accepts the last result so no extra one slips in.
            if (acc_d == size_q) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (fifo_empty) state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase

      if (push) begin
         lo_d[wr_ptr_q]  = {out_procc3, out_procc2, out_procc1, out_procc0};
         hi_d[wr_ptr_q]  = {out_extra_procc3, out_extra_procc2,
                            out_extra_procc1, out_extra_procc0};
         idx_d[wr_ptr_q] = acc_q;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         instr_q  <= '0;
         size_q   <= '0;
         acc_q    <= '0;
         ovr_q    <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            lo_q[i]  <= '0;
            hi_q[i]  <= '0;
            idx_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         instr_q  <= instr_d;
         size_q   <= size_d;
         acc_q    <= acc_d;
         ovr_q    <= ovr_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         lo_q     <= lo_d;
         hi_q     <= hi_d;
         idx_q    <= idx_d;
      end
   end

   // Record fields read as zero whenever nothing is queued.
   assign mc_wr_valid   = !fifo_empty;
   assign mc_wr_data_lo = fifo_empty ? '0 : lo_q[rd_ptr_q];
   assign mc_wr_data_hi = fifo_empty ? '0 : hi_q[rd_ptr_q];
   assign mc_wr_index   = fifo_empty ? '0 : idx_q[rd_ptr_q];
   assign mc_wr_instr   = instr_q;
   assign busy          = (state_q != S_IDLE);
   assign done          = (state_q == S_DONE);
   assign overrun       = ovr_q;

endmodule
